exhaustive_vector_sequencer: RTL
================================

# exhaustive_vector_sequencer

Hardware controller that sequences exhaustive stimulus into a combinational or sequential block under test, walking every input vector 0 to 2^N_IN−1. For each vector it waits a programmable settle time and samples the DUT response. It emits one (vector, response) record per vector over a valid/ready stream and folds every response into a MISR signature for trojan-detection comparison. It sits between the DUT's input pins and the result logger or signature checker, replacing time-delay bench sequencing with a synthesizable, cycle-exact sweep.

## Interface
- N_IN, 5, DUT input width; sweep length 2^N_IN
- N_OUT, 1, DUT response width
- SETTLE_CYC, 1, cycles vec_o is held before sampling; ≥1
- SIG_W, 16, MISR width; ≥ N_OUT
- CK  in  1  clock, all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin sweep; accepted in IDLE or DONE only
- abort  in  1  cancel sweep; return to IDLE
- vec_o  out  N_IN  stimulus to DUT, unsigned; bit N_IN−1 is MSB
- resp_i  in  N_OUT  DUT response
- rec_valid  out  1  record available
- rec_ready  in  1  sink accepts record
- rec_vec  out  N_IN  vector of the current record
- rec_resp  out  N_OUT  sampled response of the current record
- busy  out  1  high in SETTLE, CAPTURE and EMIT
- done  out  1  sweep complete; held until next start, abort or reset
- signature  out  SIG_W  running MISR value

## Operation
- States:
  - IDLE: waiting for start.
  - SETTLE: vec_o held for exactly SETTLE_CYC cycles via a down-counter.
  - CAPTURE: 1 cycle; resp_i is registered into rec_resp at the exiting edge, rec_vec is loaded with vec_o, and the MISR is updated.
  - EMIT: rec_valid is high.
  - DONE: done is high.
- Transitions:
  - IDLE/DONE + start & !abort → SETTLE. Entering clears vec_o, signature and done.
  - SETTLE → CAPTURE when the settle count expires.
  - CAPTURE → EMIT.
  - EMIT + rec_ready: if vec_o == 2^N_IN−1 → DONE; otherwise vec_o+1 → SETTLE.
  - EMIT + !rec_ready: stay in EMIT. Records and vec_o are stable.
- MISR step: sig' = (sig << 1) ^ (sig[SIG_W−1] ? MISR_POLY : 0) ^ zero-extend(resp).
- vec_o increments only on an EMIT handshake. It never wraps inside a sweep; the terminal vector ends the sweep.
- start in SETTLE, CAPTURE or EMIT is ignored.
- abort in any non-IDLE state → IDLE next cycle. It clears rec_valid, busy and done; signature is frozen.
- abort has priority over start and over a same-cycle EMIT handshake. That record is considered consumed, and no further records are emitted.
- abort in IDLE has no effect.

## Timing
- Reset values: vec_o=0, rec_valid=0, rec_vec=0, rec_resp=0, busy=0, done=0, signature=0, state IDLE.
- Reset mid-sweep forces all reset values asynchronously.
- Handshake rule: rec_valid, once high, stays high with stable rec_vec/rec_resp until the handshake completes. abort and reset are the only exceptions.
- start sampled at edge k → SETTLE and busy=1 from k+1.
- Per vector with rec_ready tied high: SETTLE_CYC+2 cycles.
- Full sweep: 2^N_IN·(SETTLE_CYC+2) cycles from start acceptance to DONE. Default: 96 cycles.
- signature is final once done rises; it updates only on CAPTURE exit edges.

## Structure
- Package exh_seq_pkg:
  - state enum (IDLE, SETTLE, CAPTURE, EMIT, DONE)
  - MISR_POLY localparam default 16'h1021
  - a function for the MISR step
- One sub-module, exh_misr: SIG_W register with a clear and an enable that fires on CAPTURE, taking resp_i.
- FSM, settle counter and vector counter stay in the top module.

## Test plan
- Defaults, DUT resp_i = ^vec_o, rec_ready=1, start pulse → exactly 32 records, rec_vec 0..31 in order, rec_resp = parity of rec_vec, done at cycle 96 after acceptance.
- N_IN=2, resp_i tied 1, rec_ready=1 → signature 0x0001, 0x0003, 0x0007, then final 0x000F with done=1.
- rec_ready toggled randomly (~30% low) → rec_valid/rec_vec/rec_resp stable while stalled; same 32 records, no drops or duplicates.
- SETTLE_CYC=3, DUT registered with one-cycle delay → every rec_resp matches the vector's function; vec_o held 3 cycles per vector.
- abort asserted in EMIT of vector 7, together with start → IDLE next cycle, rec_valid=0, done=0, signature frozen; a later start sweeps from 0.
- reset asserted mid-SETTLE of vector 12 → all outputs 0 immediately, no record emitted; start after release gives a full clean sweep.

Source files
------------

// File: rtl/exh_seq_pkg.sv
// Shared types and the MISR step for the exhaustive vector sequencer.
// The MISR step works on a 64-bit carrier so one function serves any SIG_W up to 64.
package exh_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        EMIT,
        DONE
    } state_t;

    localparam logic [15:0] MISR_POLY = 16'h1021;

    function automatic logic [63:0] misr_step(
        input logic [63:0] sig,
        input logic [63:0] resp,
        input int unsigned w
    );
        logic [63:0] mask;
        logic [63:0] msb_sh;
        logic [63:0] nxt;
        mask   = (w >= 32'd64) ? '1 : ((64'd1 << w) - 64'd1);
        msb_sh = sig >> (w - 32'd1);
        nxt    = (sig << 1) ^ resp;
        if (msb_sh[0]) begin
            nxt = nxt ^ {48'd0, MISR_POLY};
        end
        return nxt & mask;
    endfunction

endpackage

// File: rtl/exh_misr.sv
// Response signature register: folds one response per enable into a SIG_W MISR.
// Latency: updates on the enabling edge; clear wins over enable; no backpressure.
module exh_misr
    import exh_seq_pkg::*;
#(
    parameter int SIG_W = 16,
    parameter int N_OUT = 1
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [N_OUT-1:0] resp_i,
    output logic [SIG_W-1:0] sig
);

    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= SIG_W'(misr_step(64'(sig), 64'(resp_i), 32'(SIG_W)));
        end
    end

endmodule

// File: rtl/exhaustive_vector_sequencer.sv
// Walks every N_IN-bit vector into a block under test and streams (vector, response) records.
// Latency: SETTLE_CYC+2 cycles per vector with the sink always ready.
// Backpressure: a stalled record holds the FSM in EMIT with vec_o and the record frozen.
module exhaustive_vector_sequencer
    import exh_seq_pkg::*;
#(
    parameter int N_IN       = 5,
    parameter int N_OUT      = 1,
    parameter int SETTLE_CYC = 1,
    parameter int SIG_W      = 16
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic [N_IN-1:0]  vec_o,
    input  logic [N_OUT-1:0] resp_i,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [N_IN-1:0]  rec_vec,
    output logic [N_OUT-1:0] rec_resp,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature
);

    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [N_IN-1:0]  VEC_LAST = '1;

    state_t           state;
    logic [CNT_W-1:0] settle_cnt;
    logic             sweep_go;
    logic             cap_en;

    // abort outranks start even in DONE, so a start+abort pair never begins a sweep
    assign sweep_go = ((state == IDLE) || (state == DONE)) && start && !abort;
    assign cap_en   = (state == CAPTURE) && !abort;

    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            settle_cnt <= '0;
            vec_o      <= '0;
            rec_valid  <= 1'b0;
            rec_vec    <= '0;
            rec_resp   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (abort && (state != IDLE)) begin
            state     <= IDLE;
            rec_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (sweep_go) begin
                        state      <= SETTLE;
                        settle_cnt <= CNT_LOAD;
                        vec_o      <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= CAPTURE;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                CAPTURE: begin
                    rec_vec   <= vec_o;
                    rec_resp  <= resp_i;
                    rec_valid <= 1'b1;
                    state     <= EMIT;
                end
                EMIT: begin
                    if (rec_ready) begin
                        rec_valid <= 1'b0;
                        if (vec_o == VEC_LAST) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            vec_o      <= vec_o + 1'b1;
                            settle_cnt <= CNT_LOAD;
                            state      <= SETTLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    exh_misr #(
        .SIG_W (SIG_W),
        .N_OUT (N_OUT)
    ) u_misr (
        .CK     (CK),
        .reset  (reset),
        .clr    (sweep_go),
        .en     (cap_en),
        .resp_i (resp_i),
        .sig    (signature)
    );

endmodule
